// File: rtl/cpu_io_collector.sv
// cpu_io_collector: captures CPU output words into a FIFO and ships each one as a serial frame.
module cpu_io_collector #(
   parameter int DATAWIDTH    = 25,
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_req_i,
   input  logic                     out_flag_ioe_i,
   input  logic [DATAWIDTH-1:0]     cpu_out_i,
   output logic                     start_io_o,
   output logic                     tx_serial_o,
   output logic                     tx_busy_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o,
   output logic                     overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(DATAWIDTH);
   typedef enum logic {IDLE, RUN} run_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_t;
   run_t run_q, run_d;
   tx_t tx_q;
   logic req_q, req_prev_q;
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] count_q, count_d;
   logic [BW-1:0] baud_q;
   logic [NW-1:0] bit_q;
   logic [DATAWIDTH-1:0] shift_q;
   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic push, pop, accept, bit_end;
   always_comb begin
      run_d   = (req_q && !req_prev_q) ? ((run_q == RUN) ? IDLE : RUN) : run_q;
      push    = (run_q == RUN) && out_flag_ioe_i;
      pop     = (tx_q == TX_IDLE) && (count_q != '0);
      accept  = push && ((count_q != (AW+1)'(DEPTH)) || pop);
      count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop);
      bit_end = baud_q == BW'(CLKS_PER_BIT-1);
   end
   assign fifo_count_o = count_q;
   always_ff @(posedge clk_i) begin
      if (accept) mem_q[wr_q] <= cpu_out_i;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         req_q       <= 1'b0;
         req_prev_q  <= 1'b0;
         run_q       <= IDLE;
         start_io_o  <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         overflow_o  <= 1'b0;
         tx_q        <= TX_IDLE;
         tx_serial_o <= 1'b1;
         tx_busy_o   <= 1'b0;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
      end else begin
         req_q      <= start_req_i;
         req_prev_q <= req_q;
         run_q      <= run_d;
         start_io_o <= run_d == RUN;
         count_q    <= count_d;
         if (accept) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         if (push && !accept) overflow_o <= 1'b1;
         baud_q <= (tx_q == TX_IDLE || bit_end) ? '0 : baud_q + BW'(1);
         case (tx_q)
            TX_IDLE: if (pop) begin
               shift_q     <= mem_q[rd_q];
               tx_q        <= TX_START;
               tx_serial_o <= 1'b0;
               tx_busy_o   <= 1'b1;
            end
            TX_START: if (bit_end) begin
               tx_q        <= TX_DATA;
               tx_serial_o <= shift_q[0];
            end
            TX_DATA: if (bit_end) begin
               if (bit_q == NW'(DATAWIDTH-1)) begin
                  tx_q        <= TX_STOP;
                  tx_serial_o <= 1'b1;
                  bit_q       <= '0;
               end else begin
                  bit_q       <= bit_q + NW'(1);
                  shift_q     <= shift_q >> 1;
                  tx_serial_o <= shift_q[1];
               end
            end
            default: if (bit_end) begin
               tx_q      <= TX_IDLE;
               tx_busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_io_collector.sv
// tb_cpu_io_collector: vector table, directed corner sequences and a queue-based random model for cpu_io_collector.
module tb_cpu_io_collector;
   localparam int DW = 25, DEPTH = 8, CPB = 4, FRAME = (DW + 2) * CPB;
   logic clk = 1'b0, rst_n = 1'b0, start_req = 1'b0, flag = 1'b0;
   logic [DW-1:0] data = '0;
   logic start_io, tx, busy, ovf;
   logic [3:0] count;
   int checks = 0, failures = 0;
   logic [DW-1:0] rx_q[$];
   cpu_io_collector #(.DATAWIDTH(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_req_i(start_req), .out_flag_ioe_i(flag),
      .cpu_out_i(data), .start_io_o(start_io), .tx_serial_o(tx), .tx_busy_o(busy),
      .fifo_count_o(count), .overflow_o(ovf)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // serial receiver: samples each bit mid-cell and measures the busy window of every frame
   int rs = -1, rbusy = 0;
   logic [DW-1:0] rword;
   always @(negedge clk) begin
      if (!rst_n) rs = -1;
      else begin
         if (rs < 0 && tx === 1'b0) begin
            rs = 0;
            rbusy = 0;
         end
         if (rs >= 0) begin
            if (busy === 1'b1) rbusy++;
            if (rs == CPB / 2) check("start_bit", 32'(tx), 0);
            if (rs >= CPB + CPB / 2 && rs < (DW + 1) * CPB && rs % CPB == CPB / 2) rword[(rs - CPB) / CPB] = tx;
            if (rs == (DW + 1) * CPB + CPB / 2) check("stop_bit", 32'(tx), 1);
            if (rs == FRAME) begin
               check("busy_len", rbusy, FRAME);
               rx_q.push_back(rword);
               rs = -1;
            end else rs++;
         end
      end
   end
   task automatic do_reset();
      rst_n = 1'b0;
      start_req = 1'b0;
      flag = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask
   task automatic go_run();
      start_req = 1'b1;
      tick();
      tick();
      start_req = 1'b0;
      tick();
      check("start_io_run", 32'(start_io), 1);
   endtask
   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check("rx_frames", rx_q.size(), n);
   endtask
   logic m_cur, m_prev, m_run, m_ovf;
   int m_left;
   logic [DW-1:0] m_q[$], m_sent[$];
   task automatic mstep();
      logic nrun;
      nrun = (m_cur && !m_prev) ? !m_run : m_run;
      if (m_left == 0 && m_q.size() > 0) begin
         m_sent.push_back(m_q.pop_front());
         m_left = FRAME;
      end else if (m_left > 0) m_left--;
      if (m_run && flag) begin
         if (m_q.size() < DEPTH) m_q.push_back(data);
         else m_ovf = 1'b1;
      end
      m_prev = m_cur;
      m_cur = start_req;
      m_run = nrun;
   endtask
   task automatic mcheck();
      check("rand_count", 32'(count), m_q.size());
      check("rand_ovf", 32'(ovf), 32'(m_ovf));
      check("rand_start", 32'(start_io), 32'(m_run));
      check("rand_busy", 32'(busy), 32'(m_left > 0));
   endtask
   typedef struct {logic req; logic flg; logic exp_start;} vec_t;
   vec_t tbl [19];
   logic [DW-1:0] exp_w [10];
   initial begin
      tbl = '{'{1'b0,1'b1,1'b0}, '{1'b0,1'b1,1'b0}, '{1'b0,1'b1,1'b0}, '{1'b0,1'b1,1'b0},
              '{1'b1,1'b1,1'b0}, '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b1},
              '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b1},
              '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b1}, '{1'b0,1'b0,1'b1}, '{1'b0,1'b0,1'b1},
              '{1'b1,1'b0,1'b1}, '{1'b1,1'b0,1'b0}, '{1'b0,1'b0,1'b0}};
      do_reset();
      check("rst_start", 32'(start_io), 0);
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_count", 32'(count), 0);
      check("rst_ovf", 32'(ovf), 0);
      for (int i = 0; i < 19; i++) begin
         start_req = tbl[i].req;
         flag = tbl[i].flg;
         data = DW'(i + 5);
         tick();
         check("tbl_start", 32'(start_io), 32'(tbl[i].exp_start));
         check("tbl_count", 32'(count), 0);
         check("tbl_tx", 32'(tx), 1);
         check("tbl_busy", 32'(busy), 0);
      end
      flag = 1'b0;
      rx_q.delete();
      go_run();
      flag = 1'b1;
      data = 25'h1A5A5A5;
      tick();
      flag = 1'b0;
      check("single_count_push", 32'(count), 1);
      tick();
      check("single_count_pop", 32'(count), 0);
      check("single_busy", 32'(busy), 1);
      check("single_tx_start", 32'(tx), 0);
      wait_rx(1, FRAME + 20);
      if (rx_q.size() > 0) check("single_word", 32'(rx_q[0]), 32'h1A5A5A5);
      rx_q.delete();
      flag = 1'b1;
      data = 25'h100;
      tick();
      for (int k = 1; k <= 10; k++) begin
         data = DW'(k);
         tick();
         check("burst_count", 32'(count), (k < DEPTH) ? k : DEPTH);
         check("burst_ovf", 32'(ovf), 32'(k > DEPTH));
      end
      flag = 1'b0;
      wait_rx(9, 9 * (FRAME + 1) + 40);
      exp_w[0] = 25'h100;
      for (int i = 1; i < 9; i++) exp_w[i] = DW'(i);
      for (int i = 0; i < 9; i++) if (i < rx_q.size()) check("burst_word", 32'(rx_q[i]), 32'(exp_w[i]));
      rx_q.delete();
      flag = 1'b1;
      data = 25'h11;
      tick();
      data = 25'h22;
      tick();
      data = 25'h33;
      tick();
      flag = 1'b0;
      for (int k = 0; k < 39; k++) tick();
      check("mid_busy", 32'(busy), 1);
      check("mid_count", 32'(count), 2);
      rst_n = 1'b0;
      tick();
      check("abort_tx", 32'(tx), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_count", 32'(count), 0);
      check("abort_start", 32'(start_io), 0);
      check("abort_ovf", 32'(ovf), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 2 * FRAME + 20; k++) tick();
      check("abort_no_frames", rx_q.size(), 0);
      check("abort_tx_idle", 32'(tx), 1);
      go_run();
      flag = 1'b1;
      data = 25'hAA;
      tick();
      for (int k = 11; k <= 18; k++) begin
         data = DW'(k);
         tick();
      end
      flag = 1'b0;
      check("full_count", 32'(count), DEPTH);
      for (int k = 0; k < FRAME + 10 && busy; k++) tick();
      check("full_wait_idle", 32'(busy), 0);
      flag = 1'b1;
      data = 25'h77;
      tick();
      flag = 1'b0;
      check("full_pushpop_count", 32'(count), DEPTH);
      check("full_pushpop_ovf", 32'(ovf), 0);
      wait_rx(10, 10 * (FRAME + 1) + 40);
      exp_w[0] = 25'hAA;
      for (int i = 1; i < 9; i++) exp_w[i] = DW'(i + 10);
      exp_w[9] = 25'h77;
      for (int i = 0; i < 10; i++) if (i < rx_q.size()) check("full_word", 32'(rx_q[i]), 32'(exp_w[i]));
      do_reset();
      rx_q.delete();
      m_cur = 1'b0; m_prev = 1'b0; m_run = 1'b0; m_ovf = 1'b0; m_left = 0;
      m_q.delete();
      m_sent.delete();
      for (int c = 0; c < 3000; c++) begin
         if (c == 3 || $urandom_range(0, 79) == 0) start_req = ~start_req;
         flag = ($urandom_range(0, (c < 1500) ? 3 : 15) == 0);
         data = DW'($urandom);
         mstep();
         tick();
         mcheck();
      end
      flag = 1'b0;
      for (int k = 0; k < 12 * (FRAME + 1) && (m_q.size() > 0 || m_left > 0 || rx_q.size() < m_sent.size()); k++) begin
         mstep();
         tick();
         mcheck();
      end
      check("rand_frames", rx_q.size(), m_sent.size());
      for (int i = 0; i < m_sent.size(); i++) if (i < rx_q.size()) check("rand_word", 32'(rx_q[i]), 32'(m_sent[i]));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_io_collector.md
CPU_IO_COLLECTOR -- requirements
Module: cpu_io_collector

Interface
REQ-001 Parameter DATAWIDTH, default 25, SHALL set the width of the captured CPU output word.
REQ-002 Parameter DEPTH, default 8 (power of 2), SHALL set the number of FIFO entries.
REQ-003 Parameter CLKS_PER_BIT, default 4 (>=2), SHALL set the clock cycles per serial bit.
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  reset; synchronous, active-low.
REQ-006 startReq  in  1  run/stop request level from the board; each rising edge toggles the run state.
REQ-007 outFlagIOE  in  1  CPU output-valid flag, Execute stage.
REQ-008 cpuOut  in  DATAWIDTH  CPU output word, qualified by outFlagIOE.
REQ-009 startIO  out  1  run enable to the CPU; high only in state RUN.
REQ-010 txSerial  out  1  serial frame line; idle high.
REQ-011 txBusy  out  1  high while a frame is being shifted.
REQ-012 fifoCount  out  log2(DEPTH)+1  number of occupied FIFO entries.
REQ-013 overflow  out  1  sticky flag; set when a word is dropped.

Function
REQ-014 Run FSM SHALL have states IDLE and RUN.
REQ-015 The block SHALL register startReq and detect a rising edge as current=1 and previous=0.
REQ-016 On a detected edge, the FSM SHALL go IDLE->RUN or RUN->IDLE on the next clock edge.
REQ-017 startIO SHALL be a registered output equal to (state==RUN).
REQ-018 Capture: on each clock edge where state==RUN and outFlagIOE==1, cpuOut SHALL be pushed, one word per cycle, including consecutive cycles.
REQ-019 outFlagIOE SHALL be ignored in IDLE.
REQ-020 FIFO ordering SHALL be first-in first-out with circular read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-021 A push while full with no pop in the same cycle SHALL drop the word, leave the FIFO unchanged, and set overflow.
REQ-022 A push and a pop in the same cycle SHALL both be accepted, with fifoCount unchanged, including when the FIFO is full.
REQ-023 A pop SHALL occur only when fifoCount>0.
REQ-024 Entering IDLE SHALL neither flush the FIFO nor stop transmission.
REQ-025 TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA and TX_STOP.
REQ-026 In TX_IDLE with fifoCount>0, the FIFO head SHALL be popped into the shift register and the FSM SHALL go to TX_START on that edge.
REQ-027 TX_START SHALL drive txSerial=0 for CLKS_PER_BIT cycles.
REQ-028 TX_DATA SHALL drive DATAWIDTH bits LSB first, each for CLKS_PER_BIT cycles, using a bit counter of 0..DATAWIDTH-1.
REQ-029 TX_STOP SHALL drive txSerial=1 for CLKS_PER_BIT cycles, then go to TX_IDLE.
REQ-030 TX_IDLE SHALL last at least one cycle.
REQ-031 Frame length SHALL be (DATAWIDTH+2)*CLKS_PER_BIT cycles: 108 at the defaults.
REQ-032 txSerial and txBusy SHALL be registered; txBusy SHALL be 1 in TX_START, TX_DATA and TX_STOP.
REQ-033 First-word latency: a word pushed at edge N SHALL be popped at edge N+1 if the TX FSM is idle, and txSerial SHALL fall after edge N+1.
REQ-034 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.

Reset
REQ-035 While reset==0 at a clock edge, the block SHALL enter: run state IDLE, TX state TX_IDLE, pointers 0, fifoCount=0, overflow=0, startIO=0, txSerial=1, txBusy=0, baud and bit counters 0.
REQ-036 Reset asserted mid-frame SHALL abort the frame and discard the FIFO contents.
REQ-037 overflow SHALL clear only on reset.

Verification
REQ-038 Run toggle: reset released, startReq held low then high for 10 cycles -> startIO=1 from 2 edges after the rise; second rise -> startIO=0; no toggle on the level hold.
REQ-039 Single frame: RUN, one-cycle outFlagIOE with cpuOut=0x1A5A5A5 -> fifoCount 1 then 0; txSerial = 0, then bits 1,0,1,0,... LSB first, then 1; txBusy high for exactly 108 cycles.
REQ-040 Burst and overflow: RUN, outFlagIOE high 10 consecutive cycles, values 1..10, while the TX FSM is busy on a prior frame -> fifoCount saturates at 8, overflow=1, later frames carry 1..8 in order.
REQ-041 Simultaneous full push/pop: FIFO full, push on the pop cycle -> fifoCount stays 8, overflow stays 0, the pushed word is sent last.
REQ-042 IDLE gating: IDLE state, outFlagIOE=1 for 5 cycles -> fifoCount=0, txSerial=1 constant.
REQ-043 Reset mid-frame: reset low at cycle 40 of a frame -> next cycle txSerial=1, txBusy=0, fifoCount=0, startIO=0.
